alu_issue_stage: RTL

Decode/issue pipeline stage that drives the integer ALU's operand and control interface (in1, in2, shamt, use_shamt, funct3, funct7).
- Accepts a fetched RV32I instruction plus register-file read data.
- Decodes OP, OP-IMM, LUI and AUIPC into registered ALU controls.
- Presents them downstream through a valid/ready handshake.
- Uses a 2-entry skid buffer, so in_ready is a registered signal and back-pressure never creates a combinational path.

---
 rtl/rv32_pkg.sv | 34 +++
 rtl/rv32_alu_decode.sv | 62 ++++++
 rtl/alu_issue_stage.sv | 80 ++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I constants and the decoded ALU request record used by the issue stage.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [4:0]      shamt;
    logic            use_shamt;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            illegal;
  } alu_req_t;

endpackage

// File: rtl/rv32_alu_decode.sv
// Combinational RV32I decode of OP, OP-IMM, LUI and AUIPC into an ALU request.
module rv32_alu_decode
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_req_t    req
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    req    = '0;
    legal  = 1'b1;
    req.rd = instr[11:7];
    case (opcode)
      OPC_OP: begin
        req.in1    = rs1_data;
        req.in2    = rs2_data;
        req.funct3 = f3;
        req.funct7 = f7;
        legal      = (f7 == F7_BASE) ||
                     ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));
      end
      OPC_OP_IMM: begin
        req.in1    = rs1_data;
        req.in2    = {{20{instr[31]}}, instr[31:20]};
        req.funct3 = f3;
        if ((f3 == F3_SLL) || (f3 == F3_SRL)) begin
          req.use_shamt = 1'b1;
          req.shamt     = instr[24:20];
          req.funct7    = f7;
          legal         = (f7 == F7_BASE) || ((f3 == F3_SRL) && (f7 == F7_ALT));
        end
      end
      OPC_LUI: begin
        req.in2 = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        req.in1 = pc;
        req.in2 = {instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries carry only rd and the flag so execute sees inert controls.
    if (!legal) begin
      req         = '0;
      req.rd      = instr[11:7];
      req.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decoder followed by a 2-entry skid buffer with registered in_ready.
module alu_issue_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] in2,
  output logic [4:0]      shamt,
  output logic            use_shamt,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic            illegal
);

  alu_req_t         dec_req;
  alu_req_t         main_q;
  alu_req_t         skid_q;
  logic [DEPTH-1:0] valid_q;  // [0] main entry, [1] skid entry
  logic             in_fire;
  logic             out_fire;

  rv32_alu_decode u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .req      (dec_req)
  );

  assign in_ready  = ~valid_q[1];
  assign out_valid = valid_q[0];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = valid_q[0] && out_ready;

  // in_ready is low whenever skid holds, so a refill from skid never races a new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (out_fire && valid_q[1]) begin
      main_q     <= skid_q;
      valid_q[1] <= 1'b0;
    end else if (in_fire && (!valid_q[0] || out_fire)) begin
      main_q     <= dec_req;
      valid_q[0] <= 1'b1;
    end else if (in_fire) begin
      skid_q     <= dec_req;
      valid_q[1] <= 1'b1;
    end else if (out_fire) begin
      valid_q[0] <= 1'b0;
    end
  end

  assign in1       = main_q.in1;
  assign in2       = main_q.in2;
  assign shamt     = main_q.shamt;
  assign use_shamt = main_q.use_shamt;
  assign funct3    = main_q.funct3;
  assign funct7    = main_q.funct7;
  assign rd        = main_q.rd;
  assign illegal   = main_q.illegal;

endmodule
